// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and the transmitter.
//   uart_state_e  - receive/transmit frame FSM states
//   DATA_BITS     - payload bits per 8N1 frame
//   clks_per_bit  - core clocks per serial bit for a given clock and line rate
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_per_sec,
                                               input int unsigned baud_rate);
    return clk_per_sec / baud_rate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
//   clk   - destination clock
//   reset - asynchronous, active-high; both flops reset to 1 (idle-high line)
//   d     - asynchronous input
//   q     - synchronised output, two clk cycles behind d
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a one-entry output buffer.
//   clk       - core clock
//   reset     - asynchronous, active-high
//   rxd       - serial input, asynchronous, idle high
//   rx_data   - received byte, stable while rx_valid is high
//   rx_valid  - rx_data holds an unconsumed byte
//   rx_ready  - consumer takes rx_data on a cycle with rx_valid & rx_ready
//   frame_err - one-cycle pulse: stop bit sampled low, byte dropped
//   overrun   - one-cycle pulse: byte completed while buffer full, byte dropped
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_SEC = 40000000,
  parameter int unsigned BAUD_RATE   = 200000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_PER_SEC, BAUD_RATE);
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIDX_W       = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIDX_W-1:0] IDX_LAST  = BIDX_W'(DATA_BITS - 1);

  uart_state_e state_q, state_d;

  logic                 s;
  logic                 s_d_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  // FSM control strobes
  logic shift_en;
  logic stop_sample;
  logic cnt_clr;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rxd),
    .q     (s)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (s_d_q && !s) state_d = StStart;
      end
      StStart: begin
        // Re-check the line at mid start bit to reject short glitches
        if (cnt_q == HALF_LAST) state_d = s ? StIdle : StData;
      end
      StData: begin
        if (cnt_q == BIT_LAST && bit_idx_q == IDX_LAST) state_d = StStop;
      end
      StStop: begin
        if (cnt_q == BIT_LAST) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    shift_en    = (state_q == StData) && (cnt_q == BIT_LAST);
    stop_sample = (state_q == StStop) && (cnt_q == BIT_LAST);
    // Bit timing restarts on every state change and after every data sample
    cnt_clr     = (state_q == StIdle) || (state_d != state_q) || shift_en;
  end

  // Datapath and output buffer next state
  always_comb begin
    cnt_d       = cnt_clr ? '0 : cnt_q + 1'b1;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = stop_sample && !s;
    overrun_d   = 1'b0;

    if (state_q == StStart) begin
      bit_idx_d = '0;
    end else if (shift_en) begin
      bit_idx_d = bit_idx_q + 1'b1;
    end

    // LSB arrives first, so shift in from the top
    if (shift_en) shreg_d = {s, shreg_q[DATA_BITS-1:1]};

    if (stop_sample && s) begin
      // A handshake in the same cycle frees the buffer for the new byte
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shreg_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_d_q       <= 1'b1;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      s_d_q       <= s;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
